// File: rtl/pixel_compositor_if.sv
// Pixel stream between the sprite/tile generators, the compositor and the VGA output pins.
interface pixel_compositor_if #(
  parameter int unsigned NUM_LAYERS = 8
);
  logic                     valid;
  logic [9:0]               v_cnt;
  logic [12*NUM_LAYERS-1:0] pixels;
  logic [NUM_LAYERS-1:0]    layer_en;
  logic [11:0]              RGB;

  modport master (output valid, v_cnt, pixels, layer_en, input RGB);
  modport slave (input valid, v_cnt, pixels, layer_en, output RGB);
endinterface

// File: rtl/pixel_compositor.sv
// Two-stage layer compositor: priority select over NUM_LAYERS pixels, then a frame-synchronous
// brightness fade. Layer 0 can blink after damage.
module pixel_compositor #(
  parameter int unsigned NUM_LAYERS      = 8,
  parameter int unsigned HUD_ROWS        = 40,
  parameter logic [11:0] HUD_COLOR       = 12'h000,
  parameter logic [11:0] BG_COLOR        = 12'hFDA,
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned FLASH_FRAMES    = 32
) (
  input  logic              clk,
  input  logic              rst,
  pixel_compositor_if.slave pix,
  input  logic              frame_start,
  input  logic              fade_out_req,
  input  logic              fade_in_req,
  input  logic              flash_req,
  output logic              fade_busy,
  output logic              fade_black
);
  localparam int unsigned StepW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {StIdle, StFadeOut, StBlack, StFadeIn} state_e;

  state_e           state_q;
  logic [4:0]       level_q;
  logic [StepW-1:0] step_q;
  logic             out_pend_q, in_pend_q;
  logic [7:0]       flash_q;
  logic [11:0]      sel_color, color_q, rgb_q;
  logic             valid_q;
  logic             blink_mask, out_pend, in_pend, step_done;

  assign blink_mask = (flash_q != 8'd0) && flash_q[2];
  // A request pulsing on the frame_start cycle itself is honoured on that same frame_start.
  assign out_pend   = out_pend_q | fade_out_req;
  assign in_pend    = in_pend_q | fade_in_req;
  assign step_done  = (step_q == StepLast);

  // Walk from lowest priority up so the lowest-index visible layer overwrites the rest.
  always_comb begin
    sel_color = ({22'd0, pix.v_cnt} < HUD_ROWS) ? HUD_COLOR : BG_COLOR;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (pix.layer_en[i] && (pix.pixels[12*i +: 12] != 12'h000) && !(i == 0 && blink_mask)) begin
        sel_color = pix.pixels[12*i +: 12];
      end
    end
  end

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
    return 4'(({4'd0, c} * {3'd0, lvl}) >> 4);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      color_q <= 12'h000;
      valid_q <= 1'b0;
      rgb_q   <= 12'h000;
    end else begin
      color_q <= sel_color;
      valid_q <= pix.valid;
      rgb_q   <= valid_q ? {scale(color_q[11:8], level_q), scale(color_q[7:4], level_q),
                            scale(color_q[3:0], level_q)} : 12'h000;
    end
  end

  assign pix.RGB = rgb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      level_q    <= 5'd16;
      step_q     <= '0;
      out_pend_q <= 1'b0;
      in_pend_q  <= 1'b0;
    end else if (frame_start) begin
      // Every frame_start consumes both flags, which also drops ignored requests.
      out_pend_q <= 1'b0;
      in_pend_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (out_pend) begin
            state_q <= StFadeOut;
            step_q  <= '0;
          end
        end
        StFadeOut: begin
          if (step_done) begin
            step_q <= '0;
            if (level_q <= 5'd1) begin
              level_q <= 5'd0;
              state_q <= StBlack;
            end else begin
              level_q <= level_q - 5'd1;
            end
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        StBlack: begin
          if (in_pend) begin
            state_q <= StFadeIn;
            step_q  <= '0;
          end
        end
        StFadeIn: begin
          if (out_pend) begin
            state_q <= StFadeOut;
            step_q  <= '0;
          end else if (step_done) begin
            step_q <= '0;
            if (level_q >= 5'd15) begin
              level_q <= 5'd16;
              state_q <= StIdle;
            end else begin
              level_q <= level_q + 5'd1;
            end
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
      endcase
    end else begin
      if (fade_out_req) out_pend_q <= 1'b1;
      if (fade_in_req)  in_pend_q  <= 1'b1;
    end
  end

  // A new flash_req restarts the blink even if one is running or frame_start coincides.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_q <= 8'd0;
    end else if (flash_req) begin
      flash_q <= 8'(FLASH_FRAMES);
    end else if (frame_start && (flash_q != 8'd0)) begin
      flash_q <= flash_q - 8'd1;
    end
  end

  assign fade_busy  = (state_q == StFadeOut) || (state_q == StFadeIn);
  assign fade_black = (state_q == StBlack);
endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: vector table for the select path, scripted
// sequences for fade, flash and reset, with a two-cycle scoreboard on RGB.
module tb_pixel_compositor;
  logic clk, rst, frame_start, fade_out_req, fade_in_req, flash_req;
  logic fade_busy, fade_black;
  int   checks = 0;
  int   errors = 0;

  bit          chk_q[$];
  logic [11:0] exp_q[$];
  string       nm_q[$];

  pixel_compositor_if #(.NUM_LAYERS(8)) pif ();

  pixel_compositor dut (
    .clk         (clk),
    .rst         (rst),
    .pix         (pif),
    .frame_start (frame_start),
    .fade_out_req(fade_out_req),
    .fade_in_req (fade_in_req),
    .flash_req   (flash_req),
    .fade_busy   (fade_busy),
    .fade_black  (fade_black)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] pixels;
    logic [7:0]  en;
    logic [9:0]  v;
    logic        valid;
    logic [11:0] exp;
  } vec_t;

  function automatic logic [95:0] lay(input int idx, input logic [11:0] c);
    return 96'(c) << (12 * idx);
  endfunction

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: queue the expectation for the inputs now driven, compare the one from 2 cycles ago.
  task automatic cyc(input bit chk, input logic [11:0] exp, input string nm);
    bit          c;
    logic [11:0] e;
    string       n;
    chk_q.push_back(chk);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    if (chk_q.size() >= 2) begin
      c = chk_q.pop_front();
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      if (c) check(n, pif.RGB, e);
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      cyc(1'b0, 12'h000, "");
      frame_start = 1'b0;
      cyc(1'b0, 12'h000, "");
    end
  endtask

  task automatic pulse(input bit out_r, input bit in_r, input bit flash_r);
    fade_out_req = out_r;
    fade_in_req  = in_r;
    flash_req    = flash_r;
    cyc(1'b0, 12'h000, "");
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
    flash_req    = 1'b0;
  endtask

  task automatic set_pix(input logic [95:0] p, input logic [7:0] en, input logic [9:0] v);
    pif.pixels   = p;
    pif.layer_en = en;
    pif.v_cnt    = v;
    pif.valid    = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   cnt;

    rst = 1'b1;
    frame_start = 1'b0;
    fade_out_req = 1'b0;
    fade_in_req = 1'b0;
    flash_req = 1'b0;
    set_pix(lay(0, 12'hFFF), 8'hFF, 10'd100);
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", pif.RGB, 12'h000);
    check("reset_busy", {11'd0, fade_busy}, 12'h000);
    check("reset_black", {11'd0, fade_black}, 12'h000);
    rst = 1'b0;

    vecs[0] = '{lay(3, 12'hF00) | lay(5, 12'h0F0), 8'hFF, 10'd100, 1'b1, 12'hF00};
    vecs[1] = '{lay(3, 12'hF00) | lay(5, 12'h0F0), 8'hF7, 10'd100, 1'b1, 12'h0F0};
    vecs[2] = '{96'd0, 8'hFF, 10'd39, 1'b1, 12'h000};
    vecs[3] = '{96'd0, 8'hFF, 10'd40, 1'b1, 12'hFDA};
    vecs[4] = '{lay(3, 12'hF00), 8'hFF, 10'd100, 1'b0, 12'h000};
    vecs[5] = '{lay(7, 12'h123), 8'hFF, 10'd100, 1'b1, 12'h123};
    vecs[6] = '{lay(0, 12'h00F) | lay(1, 12'hABC), 8'hFF, 10'd100, 1'b1, 12'h00F};
    vecs[7] = '{lay(2, 12'h456), 8'hFB, 10'd500, 1'b1, 12'hFDA};
    vecs[8] = '{lay(7, 12'hFFF), 8'h80, 10'd0, 1'b1, 12'hFFF};
    for (int i = 0; i < 9; i++) begin
      pif.pixels   = vecs[i].pixels;
      pif.layer_en = vecs[i].en;
      pif.v_cnt    = vecs[i].v;
      pif.valid    = vecs[i].valid;
      cyc(1'b1, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Fade out from full brightness.
    set_pix(lay(0, 12'hFFF), 8'hFF, 10'd100);
    pulse(1'b1, 1'b0, 1'b0);
    frames(1);
    check("fo_busy_rise", {11'd0, fade_busy}, 12'h001);
    check("fo_not_black", {11'd0, fade_black}, 12'h000);
    frames(1);
    cyc(1'b1, 12'hFFF, "fo_lvl16");
    frames(1);
    cyc(1'b1, 12'hEEE, "fo_lvl15");
    frames(29);
    check("fo_31_not_black", {11'd0, fade_black}, 12'h000);
    frames(1);
    check("fo_32_black", {11'd0, fade_black}, 12'h001);
    check("fo_32_idle_busy", {11'd0, fade_busy}, 12'h000);
    cyc(1'b1, 12'h000, "black_rgb");

    pulse(1'b1, 1'b0, 1'b0);
    frames(1);
    check("out_in_black_ignored", {11'd0, fade_black}, 12'h001);

    // Fade back in over the floor colour.
    set_pix(96'd0, 8'hFF, 10'd100);
    pulse(1'b0, 1'b1, 1'b0);
    frames(1);
    check("fi_busy", {11'd0, fade_busy}, 12'h001);
    frames(31);
    cyc(1'b1, 12'hEC9, "fi_lvl15");
    frames(1);
    check("fi_done_busy", {11'd0, fade_busy}, 12'h000);
    check("fi_done_black", {11'd0, fade_black}, 12'h000);
    cyc(1'b1, 12'hFDA, "fi_restored");

    pulse(1'b0, 1'b1, 1'b0);
    frames(3);
    check("in_in_idle_busy", {11'd0, fade_busy}, 12'h000);
    cyc(1'b1, 12'hFDA, "in_in_idle_rgb");

    // Both requests during FADE_IN: the fade must turn round.
    set_pix(lay(0, 12'hFFF), 8'hFF, 10'd100);
    pulse(1'b1, 1'b0, 1'b0);
    frames(33);
    check("conf_black", {11'd0, fade_black}, 12'h001);
    pulse(1'b0, 1'b1, 1'b0);
    frames(7);
    cyc(1'b1, 12'h222, "conf_fi_lvl3");
    pulse(1'b1, 1'b1, 1'b0);
    frames(3);
    cyc(1'b1, 12'h111, "conf_fo_lvl2");
    frames(4);
    check("conf_black_again", {11'd0, fade_black}, 12'h001);
    pulse(1'b0, 1'b1, 1'b0);
    frames(33);
    check("conf_back_idle", {11'd0, fade_busy | fade_black}, 12'h000);

    // Blink on layer 0: hidden while the counter is 28..31, 20..23, 12..15, 4..7.
    set_pix(lay(0, 12'h00F), 8'hFF, 10'd100);
    pulse(1'b0, 1'b0, 1'b1);
    for (int f = 1; f <= 33; f++) begin
      frames(1);
      cnt = (f >= 32) ? 0 : 32 - f;
      cyc(1'b1, ((cnt != 0) && ((cnt % 8) >= 4)) ? 12'hFDA : 12'h00F,
          $sformatf("flash_cnt%0d", cnt));
    end
    pulse(1'b0, 1'b0, 1'b1);
    frames(10);
    pulse(1'b0, 1'b0, 1'b1);
    frames(4);
    cyc(1'b1, 12'hFDA, "retrig_28");
    frames(1);
    cyc(1'b1, 12'h00F, "retrig_27");
    frames(30);
    flash_req = 1'b1;
    frame_start = 1'b1;
    cyc(1'b0, 12'h000, "");
    flash_req = 1'b0;
    frame_start = 1'b0;
    cyc(1'b1, 12'h00F, "load_wins");
    frames(1);
    cyc(1'b1, 12'hFDA, "load_wins_next");
    frames(33);

    // Reset in the middle of a fade at level 7.
    set_pix(lay(0, 12'hFFF), 8'hFF, 10'd100);
    pulse(1'b1, 1'b0, 1'b0);
    frames(19);
    cyc(1'b1, 12'h666, "fo_lvl7");
    cyc(1'b0, 12'h000, "");
    chk_q.delete();
    exp_q.delete();
    nm_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_rgb0", pif.RGB, 12'h000);
    check("rst_mid_busy", {11'd0, fade_busy}, 12'h000);
    check("rst_mid_black", {11'd0, fade_black}, 12'h000);
    cyc(1'b1, 12'hFFF, "rst_mid_lvl16");
    check("rst_mid_rgb1", pif.RGB, 12'h000);
    cyc(1'b0, 12'h000, "");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
